cp0_unit: RTL
=============

# cp0_unit

Coprocessor-0 for the exception-capable MIPS pipeline, placed in the MEM stage directly downstream of the EX/MEM pipeline register. It consumes the MEM-stage PC, branch-delay flag and per-instruction exception flags. It prioritises these flags against external hardware interrupts and raises a single-cycle flush request `req`; the pipeline registers use `req` to clear and redirect fetch to the handler. It holds SR, Cause, EPC and PRId, and serves `mfc0`, `mtc0` and `eret`.

## Interface
- `PRID`, 32'h2022_0707, read-only value of register 15.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `en`  in  1  `mtc0` write enable (MEM stage).
- `cp0_addr`  in  5  register number for read and write.
- `cp0_wdata`  in  32  `mtc0` data.
- `cp0_rdata`  out  32  `mfc0` data (combinational).
- `vpc`  in  32  PC of the instruction in MEM.
- `bd_in`  in  1  MEM instruction is in a branch delay slot.
- `adel_if`, `ri`, `syscall`, `ov`, `adel_ld`, `ades`  in  1 each  exception flags of the MEM instruction.
- `exl_clr`  in  1  `eret` in MEM.
- `hw_int`  in  6  external interrupt lines (level).
- `req`  out  1  take exception or interrupt this cycle (combinational).
- `epc_out`  out  32  current EPC register, used by `eret`.

## Operation
- **Register map**
  - 12 SR: [15:10] IM, [1] EXL, [0] IE. All other bits read 0.
  - 13 Cause: [31] BD, [15:10] IP, [6:2] ExcCode. All other bits read 0.
  - 14 EPC: all 32 bits.
  - 15 PRId: returns `PRID`.
  - Any other address reads 0.
- **Interrupt request:** `int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`.
- **Exception request:** `exc_req = (any exception flag) & ~SR.EXL`.
- `req = int_req | exc_req`.
- **ExcCode selection**
  - Interrupt wins over exceptions; it uses code 0.
  - Otherwise the fixed priority is: `adel_if` 4 > `ri` 10 > `syscall` 8 > `ov` 12 > `adel_ld` 4 > `ades` 5.
- **On a clock edge with `req`=1**
  - SR.EXL <= 1.
  - Cause.ExcCode <= selected code.
  - Cause.BD <= `bd_in`.
  - EPC <= `bd_in` ? `vpc`-4 : `vpc`, using 32-bit modulo arithmetic.
- **`mtc0`**
  - Applies only when `en`=1 and `req`=0.
  - Address 12 writes IM, EXL and IE from the matching `cp0_wdata` bits.
  - Address 14 writes all 32 bits of EPC.
  - Writes to Cause, PRId and other addresses are ignored.
- **`exl_clr`:** when 1 and `req`=0, SR.EXL <= 0.
- **Simultaneous events:** priority is `req` > `mtc0` write to SR > `exl_clr`.
  - An `mtc0` write to SR and `exl_clr` in the same cycle: EXL takes `cp0_wdata[1]`.
- **Cause.IP:** Cause.IP <= `hw_int` every cycle, regardless of `req` or EXL.
- **Bubbles:** a bubble (all flags 0) never raises `exc_req`.
  - An interrupt during a bubble still saves `vpc`. The upstream register drives `vpc`=0x4180 after a flush.

## Timing
- **Reset:** SR, Cause and EPC all clear to 0. After reset, `req`=0, `cp0_rdata`=0 for address 12, `epc_out`=0.
- **`req`:** combinational from the current-cycle inputs and registered SR. It is asserted in the same cycle the faulting instruction sits in MEM.
- **State update:** all register updates take effect at the next `posedge clk`.
  - `req` self-clears the following cycle because EXL becomes 1.
- **`cp0_rdata` and `epc_out`:** reflect register contents before the edge. There is no write-to-read bypass; the hazard unit stalls `eret` behind an `mtc0` to EPC.
- **Reset during a pending `req`:** reset wins, and nothing is captured.
- **Nested events:** while EXL=1, interrupts and exceptions are masked; flags are ignored and never latched.

## Test plan
- **Syscall with no delay slot:** `syscall`=1, `vpc`=0x3004, `bd_in`=0, EXL=0 → `req`=1. Next cycle: EPC=0x3004, ExcCode=8, BD=0, EXL=1, `req`=0.
- **Delay slot plus priority:** `ov`=1 and `ades`=1, `bd_in`=1, `vpc`=0x3010 → EPC=0x300C, ExcCode=12, BD=1.
- **Interrupt beats exception:** `mtc0` SR=0x0000_FC01, then `hw_int`=6'b000100 with `ri`=1 → `req`=1, ExcCode=0. Cause reads 0x0000_1000 | BD.
- **Masking:** EXL=1 with `adel_ld`=1 and `hw_int`=6'h3F → `req`=0 and all registers unchanged. `eret` (`exl_clr`) → EXL=0, and `req` rises on the following cycle.
- **Writes and reads:** `mtc0` to address 13 with 0xFFFF_FFFF → Cause unchanged. `mtc0` EPC=0x0000_3ABC → `epc_out`=0x3ABC next cycle. Read address 15 → `PRID`. Read address 7 → 0.
- **Collision and reset:** `req` and `en` to SR asserted in the same cycle → SR gets EXL=1 and the `mtc0` is dropped. Assert `reset` mid-sequence → all registers 0.

Source files
------------

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 in the MEM stage.
// Holds SR, Cause, EPC and PRId. Decides between interrupts and exceptions and
// raises a single-cycle flush request. Also serves mfc0, mtc0 and eret.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2022_0707
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic        adel_if,
    input  logic        ri,
    input  logic        syscall,
    input  logic        ov,
    input  logic        adel_ld,
    input  logic        ades,
    input  logic        exl_clr,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] epc_out
);

    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    // Architectural state: only the implemented fields are stored.
    logic [5:0]  sr_im_q,  sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q,  sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic        exc_any;
    logic        int_req;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        wr_sr;
    logic        wr_epc;

    // Bits of the mtc0 data that map to no implemented field.
    logic unused_wdata;
    assign unused_wdata = ^{cp0_wdata[31:16], cp0_wdata[9:2]};

    // A bubble has every flag low, so it can never raise an exception.
    assign exc_any = adel_if | ri | syscall | ov | adel_ld | ades;
    assign int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = exc_any & ~sr_exl_q;
    assign req     = int_req | exc_req;

    assign wr_sr   = en & ~req & (cp0_addr == A_SR);
    assign wr_epc  = en & ~req & (cp0_addr == A_EPC);
    assign epc_out = epc_q;

    // Select ExcCode: an interrupt takes precedence, then the fixed exception order.
    always_comb begin
        exc_code = 5'd0;
        if (int_req)      exc_code = 5'd0;
        else if (adel_if) exc_code = 5'd4;
        else if (ri)      exc_code = 5'd10;
        else if (syscall) exc_code = 5'd8;
        else if (ov)      exc_code = 5'd12;
        else if (adel_ld) exc_code = 5'd4;
        else if (ades)    exc_code = 5'd5;
    end

    // Next-state logic. A flush beats mtc0, and an mtc0 to SR beats eret.
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (req) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = exc_code;
            cause_bd_d  = bd_in;
            epc_d       = bd_in ? (vpc - 32'd4) : vpc;
        end else begin
            if (wr_sr) begin
                sr_im_d  = cp0_wdata[15:10];
                sr_exl_d = cp0_wdata[1];
                sr_ie_d  = cp0_wdata[0];
            end else if (exl_clr) begin
                sr_exl_d = 1'b0;
            end
            if (wr_epc) epc_d = cp0_wdata;
        end
    end

    // Register update. Reset wins over a pending request. IP samples the interrupt lines every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= hw_int;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // mfc0 read port. It shows the register contents from before the edge and has no bypass.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            A_SR:    cp0_rdata = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
            A_CAUSE: cp0_rdata = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
            A_EPC:   cp0_rdata = epc_q;
            A_PRID:  cp0_rdata = PRID;
            default: cp0_rdata = 32'd0;
        endcase
    end

endmodule
